// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: R-type funct codes,
// FSM state encoding and small funct-decode helpers.
package muldiv_seq_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_mul(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU);
  endfunction

  function automatic logic is_div(input logic [5:0] f);
    return (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic op_signed(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage <-> multiply/divide sequencer interface. The pipeline side is the
// master; the sequencer owning HI/LO is the slave.
interface muldiv_seq_if #(parameter int XLEN = 32);

  logic            req_valid;
  logic [5:0]      req_funct;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            req_ready;
  logic            flush;
  logic            mf_req;
  logic            mf_stall;
  logic            busy;
  logic [XLEN-1:0] hi_o;
  logic [XLEN-1:0] lo_o;

  modport master (
    output req_valid, req_funct, rs_val, rt_val, flush, mf_req,
    input  req_ready, mf_stall, busy, hi_o, lo_o
  );

  modport slave (
    input  req_valid, req_funct, rs_val, rt_val, flush, mf_req,
    output req_ready, mf_stall, busy, hi_o, lo_o
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the {hi,lo} work register: a shift-add multiply step on an
// accumulating product, or one restoring-divide step producing one quotient bit.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div,
  input  logic [2*XLEN-1:0] work_in,
  input  logic [2*XLEN-1:0] addend,
  input  logic              mbit,
  input  logic [XLEN-1:0]   divisor,
  output logic [2*XLEN-1:0] work_out
);

  logic [2*XLEN:0] shifted;
  logic [XLEN:0]   trial;

  // The trial subtract is XLEN+1 bits wide because the shifted partial
  // remainder can reach 2*divisor-1, one bit beyond XLEN.
  always_comb begin
    shifted  = {work_in, 1'b0};
    trial    = shifted[2*XLEN:XLEN] - {1'b0, divisor};
    work_out = work_in;
    if (div) begin
      if (!trial[XLEN]) begin
        work_out = {trial[XLEN-1:0], shifted[XLEN-1:1], 1'b1};
      end else begin
        work_out = shifted[2*XLEN-1:0];
      end
    end else if (mbit) begin
      work_out = work_in + addend;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer and HI/LO owner for the EX stage.
// Optional build macro: MULDIV_EARLY_OUT_EN (multiply stops once no multiplier bits remain).
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  import muldiv_seq_pkg::*;

  localparam int CW = $clog2(XLEN) + 1;

  state_t            state, state_nx;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] work, mcand, step_out, prod_neg;
  logic [XLEN-1:0]   mplr, hi_q, lo_q, w_hi, w_lo, fix_hi, fix_lo;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              op_div, neg_lo, neg_hi;
  logic              sgn_a, sgn_b, accept, run_done;

  assign accept = bus.req_valid & bus.req_ready;
  assign sgn_a  = op_signed(bus.req_funct) & bus.rs_val[XLEN-1];
  assign sgn_b  = op_signed(bus.req_funct) & bus.rt_val[XLEN-1];
  assign mag_a  = sgn_a ? -bus.rs_val : bus.rs_val;
  assign mag_b  = sgn_b ? -bus.rt_val : bus.rt_val;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div      (op_div),
    .work_in  (work),
    .addend   (mcand),
    .mbit     (mplr[0]),
    .divisor  (mcand[XLEN-1:0]),
    .work_out (step_out)
  );

`ifdef MULDIV_EARLY_OUT_EN
  assign run_done = (!op_div && (mplr[XLEN-1:1] == '0)) || (count == CW'(XLEN - 1));
`else
  assign run_done = (count == CW'(XLEN - 1));
`endif

  // Sign fix-up: a product is negated as a whole, quotient and remainder separately.
  assign w_hi     = work[2*XLEN-1:XLEN];
  assign w_lo     = work[XLEN-1:0];
  assign prod_neg = -work;
  assign fix_hi   = op_div ? (neg_hi ? -w_hi : w_hi)
                           : (neg_lo ? prod_neg[2*XLEN-1:XLEN] : w_hi);
  assign fix_lo   = op_div ? (neg_lo ? -w_lo : w_lo)
                           : (neg_lo ? prod_neg[XLEN-1:0] : w_lo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul(bus.req_funct)) begin
              state_nx = RUN;
            end else if (is_div(bus.req_funct)) begin
              state_nx = (bus.rt_val == '0) ? FIX : RUN;
            end
          end
        end
        RUN:     if (run_done) state_nx = FIX;
        FIX:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.req_ready = (state == IDLE) & ~bus.flush;
    bus.mf_stall  = bus.mf_req & (state != IDLE);
  end

  // Divide-by-zero preloads the architectural result into work so FIX can
  // write it unchanged; the multiplicand register doubles as the divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      work   <= '0;
      mcand  <= '0;
      mplr   <= '0;
      op_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      count <= (state == RUN && !bus.flush) ? count + 1'b1 : '0;
      if (accept) begin
        if (is_mul(bus.req_funct)) begin
          work   <= '0;
          mcand  <= {{XLEN{1'b0}}, mag_a};
          mplr   <= mag_b;
          op_div <= 1'b0;
          neg_lo <= sgn_a ^ sgn_b;
          neg_hi <= sgn_a ^ sgn_b;
        end else if (is_div(bus.req_funct)) begin
          op_div <= 1'b1;
          mcand  <= {{XLEN{1'b0}}, mag_b};
          if (bus.rt_val == '0) begin
            work   <= {bus.rs_val, {XLEN{1'b1}}};
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
          end else begin
            work   <= {{XLEN{1'b0}}, mag_a};
            neg_lo <= sgn_a ^ sgn_b;
            neg_hi <= sgn_a;
          end
        end else if (bus.req_funct == FN_MTHI) begin
          hi_q <= bus.rs_val;
        end else if (bus.req_funct == FN_MTLO) begin
          lo_q <= bus.rs_val;
        end
      end else if (state == RUN && !bus.flush) begin
        work  <= step_out;
        mcand <= op_div ? mcand : {mcand[2*XLEN-2:0], 1'b0};
        mplr  <= {1'b0, mplr[XLEN-1:1]};
      end else if (state == FIX && !bus.flush) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;

endmodule
